// File: rtl/ram_upload_server_if.sv
// rtl/ram_upload_server_if.sv - hps_io upload channel between the HPS side and the RAM upload server
interface ram_upload_server_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_upload_req
    );
endinterface

// File: rtl/ram_upload_server.sv
// rtl/ram_upload_server.sv - answers HPS upload reads from game work RAM while the CPU is paused
module ram_upload_server #(
    parameter int         ADDR_WIDTH = 11,
    parameter int         SIZE       = 624,
    parameter logic [7:0] INDEX      = 8'd6,
    parameter int         TIMEOUT    = 1 << 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  save_req,
    ram_upload_server_if.slave    ioctl,
    output logic                  pause_cpu,
    input  logic                  paused,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read,
    input  logic [7:0]            ram_data,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_UP, S_PAUSE, S_SERVE, S_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  save_prev_q;
    logic                  pend_q, pend_d;
    logic [24:0]           pend_addr_q, pend_addr_d;
    logic                  fly_q, fly_d;
    logic                  fly_ok_q, fly_ok_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            din_q, din_d;

    logic        up_ok;
    logic        save_rise;
    logic        upload_req;
    logic        issue;
    logic        issue_ok;
    logic [24:0] issue_addr;

    assign up_ok     = ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX);
    assign save_rise = save_req && !save_prev_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        fly_d       = 1'b0;
        fly_ok_d    = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        upload_req  = 1'b0;
        pause_cpu   = 1'b0;
        ram_read    = 1'b0;
        issue       = 1'b0;
        issue_ok    = 1'b0;
        issue_addr  = ioctl.ioctl_addr;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (save_rise) state_d = S_REQ;
            end
            S_REQ: begin
                upload_req = 1'b1;
                timer_d    = TW'(TIMEOUT - 1);
                state_d    = S_WAIT_UP;
            end
            S_WAIT_UP: begin
                if (up_ok)                state_d = S_PAUSE;
                else if (timer_q == '0)   state_d = S_IDLE;
                else                      timer_d = timer_q - TW'(1);
            end
            S_PAUSE: begin
                pause_cpu = 1'b1;
                if (!up_ok) begin
                    pend_d  = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    if (ioctl.ioctl_rd) begin
                        pend_d      = 1'b1;
                        pend_addr_d = ioctl.ioctl_addr;
                    end
                    if (paused) state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                pause_cpu = 1'b1;
                ram_read  = paused;
                if (!up_ok) begin
                    // Any read still in flight is dropped: din is not updated.
                    pend_d  = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    if (fly_q) din_d = fly_ok_q ? ram_data : 8'h00;
                    if (fly_q || !paused) begin
                        if (ioctl.ioctl_rd) begin
                            pend_d      = 1'b1;
                            pend_addr_d = ioctl.ioctl_addr;
                        end
                    end else if (pend_q) begin
                        issue      = 1'b1;
                        issue_addr = pend_addr_q;
                        pend_d     = ioctl.ioctl_rd;
                        if (ioctl.ioctl_rd) pend_addr_d = ioctl.ioctl_addr;
                    end else if (ioctl.ioctl_rd) begin
                        issue = 1'b1;
                    end
                    if (issue) begin
                        issue_ok = ({1'b0, issue_addr} < 26'(SIZE));
                        fly_d    = 1'b1;
                        fly_ok_d = issue_ok;
                        if (issue_ok) addr_d = issue_addr[ADDR_WIDTH-1:0];
                    end
                end
            end
            S_RELEASE: begin
                pause_cpu = 1'b1;
                pend_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            save_prev_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            fly_q       <= 1'b0;
            fly_ok_q    <= 1'b0;
            addr_q      <= '0;
            din_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            save_prev_q <= save_req;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            fly_q       <= fly_d;
            fly_ok_q    <= fly_ok_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    // Out-of-range reads leave the RAM address untouched.
    assign ram_address            = addr_d;
    assign ioctl.ioctl_din        = din_q;
    assign ioctl.ioctl_upload_req = upload_req;
    assign busy                   = (state_q != S_IDLE);
endmodule
